dfr_sequencer: RTL
==================

Name: dfr_sequencer

Overview:
- Parametrised multi-sample sequencer for the DFR core.
- Runs the reservoir, then the output matrix multiply, once per input sample for a programmable number of samples.
- Supports a warm-up window where samples drive the reservoir only, with no history capture and no matrix multiply.
- Adds a per-stage watchdog, abort, and a sticky error flag. Sits between the AXI register file and the reservoir / matrix-multiply engines.

Parameters:
- CNT_WIDTH, 16, width of the sample count, warm-up count and sample index.
- TIMEOUT_CYCLES, 4096, maximum cycles a stage busy may stay high before the watchdog fires. Must be ≥2.
- TIMEOUT_WIDTH, 13, width of the watchdog counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin run; sampled in IDLE, DONE or ERROR only
- abort  in  1  cancel run; highest priority after rst
- num_samples  in  CNT_WIDTH  total samples to process; latched on accepted start
- num_init_samples  in  CNT_WIDTH  leading warm-up samples; latched on accepted start
- reservoir_busy  in  1  reservoir engine busy
- matrix_multiply_busy  in  1  matrix-multiply engine busy
- busy  out  1  run in progress
- reservoir_start  out  1  one-cycle pulse per sample
- reservoir_en  out  1  high while the reservoir stage is active
- reservoir_history_en  out  1  high with reservoir_en on non-warm-up samples only
- matrix_multiply_start  out  1  one-cycle pulse per non-warm-up sample
- sample_idx  out  CNT_WIDTH  index of the current sample, 0-based
- dfr_done  out  1  one-cycle pulse when a run completes normally
- error  out  1  sticky watchdog flag
- state_dbg  out  3  current state encoding, for the status register

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset the state goes to IDLE.
- Reset values: every output is 0, including error and sample_idx. Latched counts are cleared to 0.
- Output timing: all outputs are decoded from registered state and counters (Moore). No input-to-output combinational path.
- State encoding: IDLE=0, RES_START=1, RES_WAIT=2, MM_START=3, MM_WAIT=4, NEXT=5, DONE=6, ERROR=7.
- Accepting start (in IDLE, DONE or ERROR):
  - Latch both counts, clear sample_idx and error.
  - If num_samples==0, go to DONE directly. Otherwise go to RES_START.
- RES_START:
  - busy=1, reservoir_start=1, reservoir_en=1.
  - reservoir_history_en = (sample_idx ≥ latched init count).
  - Go to RES_WAIT and clear the watchdog.
- RES_WAIT:
  - Outputs: busy, reservoir_en and history_en held as in RES_START.
  - Guard cycle: reservoir_busy is ignored on the first RES_WAIT cycle.
  - Exit: from the second cycle on, reservoir_busy==0 leaves the state. Warm-up samples go to NEXT; other samples go to MM_START.
- MM_START:
  - busy=1, matrix_multiply_start=1, reservoir_en=0.
  - Go to MM_WAIT and clear the watchdog.
- MM_WAIT:
  - Same one-cycle guard as RES_WAIT.
  - Exit: matrix_multiply_busy==0 goes to NEXT.
- NEXT:
  - busy=1.
  - If sample_idx == num_samples-1, go to DONE. Otherwise increment sample_idx and go to RES_START.
  - sample_idx never wraps.
- DONE:
  - dfr_done=1 on the entry cycle only, then busy=0.
  - The state is held until a new start. sample_idx is held.
- Watchdog:
  - Counts every cycle in RES_WAIT and MM_WAIT.
  - Fires when the count reaches TIMEOUT_CYCLES with the relevant busy still high: go to ERROR.
- ERROR:
  - error=1 (sticky), busy=0, all enables 0, no dfr_done.
  - Left only by rst or an accepted start.
- Abort:
  - In any non-IDLE state, the next state is IDLE.
  - All enables and busy drop the following cycle. No dfr_done. error is unchanged.
  - In IDLE, abort has no effect.
- Simultaneous start and abort: abort wins; start is ignored.
- start while busy: ignored; latched counts are not modified.
- num_init_samples ≥ num_samples: every sample is warm-up. No matrix multiply is issued, and dfr_done still pulses.
- Latched values are used for the whole run; changes on num_samples or num_init_samples mid-run have no effect.

Test Plan:
- num_samples=3, num_init=0, busy models hold high 5 cycles -> 3 reservoir_start and 3 matrix_multiply_start pulses; sample_idx steps 0,1,2; a single dfr_done; busy low afterwards.
- num_samples=4, num_init=2 -> reservoir_history_en low for samples 0,1 and high for 2,3; exactly 2 matrix_multiply_start pulses.
- num_samples=0 -> dfr_done 1 cycle after start; no start pulses; busy stays 0.
- TIMEOUT_CYCLES=8, reservoir_busy stuck high -> error=1 with state_dbg=7 after 8 RES_WAIT cycles; a new start clears error and restarts at sample 0.
- Abort asserted during MM_WAIT of sample 1 -> IDLE next cycle, busy=0, no dfr_done. Separately, start and abort in the same cycle from IDLE -> stays IDLE.
- rst asserted mid-run, asynchronously between clock edges -> all outputs 0 immediately; start is accepted normally after release.

Source files
------------

// File: rtl/dfr_sequencer.sv
// -----------------------------------------------------------------------------
// dfr_sequencer
//
// Multi-sample sequencer for the DFR core. For each input sample it runs the
// reservoir engine and then, outside the warm-up window, the output matrix
// multiply engine. A per-stage watchdog catches stuck engines and parks the
// sequencer in ERROR with a sticky flag; abort returns it to IDLE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a run (accepted in IDLE, DONE or ERROR)
//   abort                    cancel the current run (wins over start)
//   num_samples              samples to process, latched on accepted start
//   num_init_samples         leading warm-up samples, latched on accepted start
//   reservoir_busy           reservoir engine busy
//   matrix_multiply_busy     matrix-multiply engine busy
//   busy                     run in progress
//   reservoir_start          one-cycle pulse per sample
//   reservoir_en             high while the reservoir stage is active
//   reservoir_history_en     reservoir_en qualified by "not a warm-up sample"
//   matrix_multiply_start    one-cycle pulse per non-warm-up sample
//   sample_idx               0-based index of the current sample
//   dfr_done                 one-cycle pulse on normal completion
//   error                    sticky watchdog flag
//   state_dbg                current state encoding
//
// Every output is a flop. The output flops are loaded from the next-state
// values, so they line up cycle-for-cycle with a Moore decode of the state
// register while leaving no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module dfr_sequencer #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic [CNT_WIDTH-1:0] num_init_samples,
  input  logic                 reservoir_busy,
  input  logic                 matrix_multiply_busy,
  output logic                 busy,
  output logic                 reservoir_start,
  output logic                 reservoir_en,
  output logic                 reservoir_history_en,
  output logic                 matrix_multiply_start,
  output logic [CNT_WIDTH-1:0] sample_idx,
  output logic                 dfr_done,
  output logic                 error,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RES_START = 3'd1;
  localparam logic [2:0] ST_RES_WAIT  = 3'd2;
  localparam logic [2:0] ST_MM_START  = 3'd3;
  localparam logic [2:0] ST_MM_WAIT   = 3'd4;
  localparam logic [2:0] ST_NEXT      = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_ERROR     = 3'd7;

  // The watchdog counter is cleared on entry to a wait state, so it holds the
  // number of wait cycles already spent. Reaching WD_LAST with busy still high
  // means the stage has been busy for TIMEOUT_CYCLES wait cycles.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ZERO = TIMEOUT_WIDTH'(0);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE  = TIMEOUT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]     CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = CNT_WIDTH'(1);

  // Control state
  logic [2:0]               state_q, state_d;
  logic [CNT_WIDTH-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0]     num_q, num_d;
  logic [CNT_WIDTH-1:0]     init_q, init_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     err_q, err_d;
  logic                     start_ok;
  logic                     warm;

  // Registered outputs and their next values
  logic busy_q, busy_d;
  logic res_start_q, res_start_d;
  logic res_en_q, res_en_d;
  logic hist_en_q, hist_en_d;
  logic mm_start_q, mm_start_d;
  logic done_q, done_d;

  // Current sample is in the warm-up window (reservoir only)
  assign warm = (idx_q < init_q);

  // Next-state, counter and latch logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    init_d   = init_q;
    wd_d     = wd_q;
    err_d    = err_q;
    start_ok = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // abort in IDLE does nothing itself but still suppresses start
          if (start && !abort) begin
            start_ok = 1'b1;
            num_d    = num_samples;
            init_d   = num_init_samples;
            idx_d    = CNT_ZERO;
            err_d    = 1'b0;
            if (num_samples == CNT_ZERO) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RES_START;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_RES_START: begin
          state_d = ST_RES_WAIT;
          wd_d    = WD_ZERO;
        end

        ST_RES_WAIT: begin
          // wd_q == 0 is the guard cycle: the engine may not have raised busy yet
          if ((wd_q != WD_ZERO) && !reservoir_busy) begin
            if (warm) begin
              state_d = ST_NEXT;
            end else begin
              state_d = ST_MM_START;
            end
          end else if (wd_q == WD_LAST) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + WD_ONE;
          end
        end

        ST_MM_START: begin
          state_d = ST_MM_WAIT;
          wd_d    = WD_ZERO;
        end

        ST_MM_WAIT: begin
          if ((wd_q != WD_ZERO) && !matrix_multiply_busy) begin
            state_d = ST_NEXT;
          end else if (wd_q == WD_LAST) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + WD_ONE;
          end
        end

        ST_NEXT: begin
          // num_q is at least 1 here, so idx never runs past num_q-1
          if (idx_q == (num_q - CNT_ONE)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + CNT_ONE;
            state_d = ST_RES_START;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state, captured into the output flops
  always_comb begin
    busy_d      = 1'b0;
    res_start_d = 1'b0;
    res_en_d    = 1'b0;
    hist_en_d   = 1'b0;
    mm_start_d  = 1'b0;
    case (state_d)
      ST_RES_START: begin
        busy_d      = 1'b1;
        res_start_d = 1'b1;
        res_en_d    = 1'b1;
        hist_en_d   = (idx_d >= init_d);
      end
      ST_RES_WAIT: begin
        busy_d    = 1'b1;
        res_en_d  = 1'b1;
        hist_en_d = (idx_d >= init_d);
      end
      ST_MM_START: begin
        busy_d     = 1'b1;
        mm_start_d = 1'b1;
      end
      ST_MM_WAIT, ST_NEXT: begin
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
    // A fresh DONE entry: either arriving from another state or a zero-length
    // run restarted while already sitting in DONE.
    done_d = (state_d == ST_DONE) && ((state_q != ST_DONE) || start_ok);
  end

  // State, counters and output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= CNT_ZERO;
      num_q       <= CNT_ZERO;
      init_q      <= CNT_ZERO;
      wd_q        <= WD_ZERO;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      res_start_q <= 1'b0;
      res_en_q    <= 1'b0;
      hist_en_q   <= 1'b0;
      mm_start_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      init_q      <= init_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      res_start_q <= res_start_d;
      res_en_q    <= res_en_d;
      hist_en_q   <= hist_en_d;
      mm_start_q  <= mm_start_d;
      done_q      <= done_d;
    end
  end

  assign busy                  = busy_q;
  assign reservoir_start       = res_start_q;
  assign reservoir_en          = res_en_q;
  assign reservoir_history_en  = hist_en_q;
  assign matrix_multiply_start = mm_start_q;
  assign sample_idx            = idx_q;
  assign dfr_done              = done_q;
  assign error                 = err_q;
  assign state_dbg             = state_q;

endmodule
